// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the parity mode constants
// common to rx_fsm and tx_fsm, plus the parity check used by the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } rx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic logic parity_error(input int mode, input logic [7:0] data,
                                        input logic pbit);
    logic x;
    x = (^data) ^ pbit;
    case (mode)
      PARITY_ODD:  return ~x;
      PARITY_EVEN: return x;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for the asynchronous RX line; resets to the idle-high level.
module rx_sync (
  input  logic clk,
  input  logic RSTn,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (!RSTn) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/rx_fsm.sv
// UART receiver: mid-bit sampling, LSB first, optional parity, one stop bit.
// Defining RX_BREAK_DET_EN adds break_det and the BREAK_WAIT state.
module rx_fsm
  import uart_pkg::*;
#(
  parameter int clk_divisor = 1000000,
  parameter int rx_num_bits = 8,
  parameter int parity      = 0
) (
  input  logic       clk,
  input  logic       RSTn,
  input  logic       RX,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
`ifdef RX_BREAK_DET_EN
  ,
  output logic       break_det
`endif
);

  localparam int CNT_W = (clk_divisor > 1) ? $clog2(clk_divisor) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(clk_divisor - 1);
  // Loading this on START entry makes the first tick land half a bit into the start bit.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(clk_divisor - clk_divisor / 2);
  localparam logic [2:0] IDX_LAST = 3'(rx_num_bits - 1);

  logic            rx_s;
  logic            tick;
  rx_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            pbit_q, pbit_d;
  logic [7:0]      data_out_q, data_out_d;
  logic            dv_q, dv_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            busy_q, busy_d;
  logic            brk_q, brk_d;

  rx_sync u_rx_sync (
    .clk  (clk),
    .RSTn (RSTn),
    .d    (RX),
    .q    (rx_s)
  );

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = tick ? '0 : cnt_q + 1'b1;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    pbit_d     = pbit_q;
    data_out_d = data_out_q;
    dv_d       = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brk_d      = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
          cnt_d   = CNT_HALF;
        end
      end
      START: begin
        if (tick) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = '0;
            shreg_d = '0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shreg_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == IDX_LAST) begin
            state_d = (parity != PARITY_NONE) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          pbit_d  = rx_s;
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          state_d    = IDLE;
          data_out_d = shreg_q;
          dv_d       = 1'b1;
          ferr_d     = ~rx_s;
          perr_d     = parity_error(parity, shreg_q, pbit_q);
`ifdef RX_BREAK_DET_EN
          if (!rx_s && (shreg_q == 8'h00) && ((parity == PARITY_NONE) || !pbit_q)) begin
            state_d    = BREAK_WAIT;
            data_out_d = data_out_q;
            dv_d       = 1'b0;
            ferr_d     = ferr_q;
            perr_d     = perr_q;
            brk_d      = 1'b1;
          end
`endif
        end
      end
      BREAK_WAIT: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!RSTn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      data_out_q <= '0;
      dv_q       <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      data_out_q <= data_out_d;
      dv_q       <= dv_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
      brk_q      <= brk_d;
    end
    shreg_q <= shreg_d;
    pbit_q  <= pbit_d;
  end

  assign data_out   = data_out_q;
  assign data_valid = dv_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;
`ifdef RX_BREAK_DET_EN
  assign break_det  = brk_q;
`else
  logic unused_brk;
  assign unused_brk = brk_q;
`endif

endmodule

// File: tb/tb_rx_fsm.sv
// Directed bench for rx_fsm: three instances cover 8N1 at divisor 16, even parity,
// and a 5-bit divisor-8 configuration used for the mid-frame reset case.
module tb_rx_fsm;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  logic rstn0, rstn2, rstn6;
  logic rx0, rx2, rx6;
  logic [7:0] dout0, dout2, dout6;
  logic dv0, dv2, dv6, perr0, perr2, perr6, ferr0, ferr2, ferr6, busy0, busy2, busy6;
`ifdef RX_BREAK_DET_EN
  logic brk0, brk2, brk6;
  int brk_n0 = 0;
`endif

  rx_fsm #(.clk_divisor(16), .rx_num_bits(8), .parity(PARITY_NONE)) u_dut0 (
    .clk(clk), .RSTn(rstn0), .RX(rx0), .data_out(dout0), .data_valid(dv0),
    .parity_err(perr0), .frame_err(ferr0), .busy(busy0)
`ifdef RX_BREAK_DET_EN
    , .break_det(brk0)
`endif
  );

  rx_fsm #(.clk_divisor(16), .rx_num_bits(8), .parity(PARITY_EVEN)) u_dut2 (
    .clk(clk), .RSTn(rstn2), .RX(rx2), .data_out(dout2), .data_valid(dv2),
    .parity_err(perr2), .frame_err(ferr2), .busy(busy2)
`ifdef RX_BREAK_DET_EN
    , .break_det(brk2)
`endif
  );

  rx_fsm #(.clk_divisor(8), .rx_num_bits(5), .parity(PARITY_NONE)) u_dut6 (
    .clk(clk), .RSTn(rstn6), .RX(rx6), .data_out(dout6), .data_valid(dv6),
    .parity_err(perr6), .frame_err(ferr6), .busy(busy6)
`ifdef RX_BREAK_DET_EN
    , .break_det(brk6)
`endif
  );

  // Per-pulse records of what each DUT presented alongside data_valid.
  int         dv_n0 = 0;
  int         dv_cyc0 [32];
  logic [7:0] dv_dat0 [32];
  logic       dv_perr0[32];
  logic       dv_ferr0[32];
  int         dv_n2 = 0, dv_n6 = 0, dv_cyc6 = 0;
  logic [7:0] last_dat2 = 0, last_dat6 = 0;
  logic       last_perr2 = 0, last_ferr2 = 0, last_ferr6 = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (dv0 && dv_n0 < 32) begin
      dv_cyc0[dv_n0]  = cyc;
      dv_dat0[dv_n0]  = dout0;
      dv_perr0[dv_n0] = perr0;
      dv_ferr0[dv_n0] = ferr0;
      dv_n0++;
    end
    if (dv2) begin
      last_dat2  = dout2;
      last_perr2 = perr2;
      last_ferr2 = ferr2;
      dv_n2++;
    end
    if (dv6) begin
      last_dat6  = dout6;
      last_ferr6 = ferr6;
      dv_cyc6    = cyc;
      dv_n6++;
    end
`ifdef RX_BREAK_DET_EN
    if (brk0) brk_n0++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rx(input int w, input logic v);
    case (w)
      0:       rx0 = v;
      2:       rx2 = v;
      default: rx6 = v;
    endcase
  endtask

  task automatic send(input int w, input int div, input logic [7:0] data, input int nbits,
                      input bit has_par, input logic pbit, input logic stop);
    set_rx(w, 1'b0);
    tick(div);
    for (int i = 0; i < nbits; i++) begin
      set_rx(w, data[i]);
      tick(div);
    end
    if (has_par) begin
      set_rx(w, pbit);
      tick(div);
    end
    set_rx(w, stop);
    tick(div);
    set_rx(w, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, n, n6;
    rx0 = 1'b1; rx2 = 1'b1; rx6 = 1'b1;
    rstn0 = 1'b0; rstn2 = 1'b0; rstn6 = 1'b0;
    tick(4);
    check("rst_data_out", dout0, 8'h00);
    check("rst_valid", dv0, 1'b0);
    check("rst_parity_err", perr0, 1'b0);
    check("rst_frame_err", ferr0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    rstn0 = 1'b1; rstn2 = 1'b1; rstn6 = 1'b1;
    tick(5);

    // single 8N1 frame
    t0 = cyc; n = dv_n0;
    send(0, 16, 8'hA5, 8, 1'b0, 1'b0, 1'b1);
    tick(20);
    check("s1_count", dv_n0 - n, 1);
    check("s1_data", dv_dat0[n], 8'hA5);
    check("s1_perr", dv_perr0[n], 1'b0);
    check("s1_ferr", dv_ferr0[n], 1'b0);
    check("s1_latency", dv_cyc0[n] - t0, 155);
    tick(30);
    check("s1_hold", dout0, 8'hA5);
    check("s1_idle_busy", busy0, 1'b0);

    // back-to-back frames
    n = dv_n0;
    send(0, 16, 8'h3C, 8, 1'b0, 1'b0, 1'b1);
    send(0, 16, 8'hC3, 8, 1'b0, 1'b0, 1'b1);
    tick(20);
    check("s2_count", dv_n0 - n, 2);
    check("s2_data0", dv_dat0[n], 8'h3C);
    check("s2_data1", dv_dat0[n+1], 8'hC3);
    check("s2_spacing", dv_cyc0[n+1] - dv_cyc0[n], 160);

    // even parity
    n = dv_n2;
    send(2, 16, 8'h07, 8, 1'b1, 1'b0, 1'b1);
    tick(20);
    check("s3_count_a", dv_n2 - n, 1);
    check("s3_data_a", last_dat2, 8'h07);
    check("s3_perr_a", last_perr2, 1'b1);
    send(2, 16, 8'h07, 8, 1'b1, 1'b1, 1'b1);
    tick(20);
    check("s3_count_b", dv_n2 - n, 2);
    check("s3_data_b", last_dat2, 8'h07);
    check("s3_perr_b", last_perr2, 1'b0);
    check("s3_ferr_b", last_ferr2, 1'b0);

    // stop bit low
    n = dv_n0;
    send(0, 16, 8'h55, 8, 1'b0, 1'b0, 1'b0);
    tick(40);
    check("s4_count", dv_n0 - n, 1);
    check("s4_data", dv_dat0[n], 8'h55);
    check("s4_ferr", dv_ferr0[n], 1'b1);
    check("s4_perr", dv_perr0[n], 1'b0);

    // line held low for ten bit times
    n = dv_n0;
    set_rx(0, 1'b0);
    tick(158);
    check("s4_brk_busy", busy0, 1'b1);
    tick(2);
    set_rx(0, 1'b1);
    tick(40);
`ifdef RX_BREAK_DET_EN
    check("s4_brk_no_valid", dv_n0 - n, 0);
    check("s4_brk_pulse", brk_n0, 1);
    check("s4_brk_data_kept", dout0, 8'h55);
`else
    check("s4_zero_count", dv_n0 - n, 1);
    check("s4_zero_data", dv_dat0[n], 8'h00);
    check("s4_zero_ferr", dv_ferr0[n], 1'b1);
`endif
    check("s4_brk_idle", busy0, 1'b0);

    // 4-cycle glitch
    n = dv_n0;
    set_rx(0, 1'b0);
    tick(4);
    set_rx(0, 1'b1);
    tick(1);
    check("s5_busy_start", busy0, 1'b1);
    tick(6);
    check("s5_busy_clear", busy0, 1'b0);
    tick(40);
    check("s5_no_valid", dv_n0 - n, 0);

    // divisor 8, 5 data bits, then reset mid-frame
    t0 = cyc; n6 = dv_n6;
    send(6, 8, 8'h1F, 5, 1'b0, 1'b0, 1'b1);
    tick(10);
    check("s6_count", dv_n6 - n6, 1);
    check("s6_data", last_dat6, 8'h1F);
    check("s6_ferr", last_ferr6, 1'b0);
    check("s6_latency", dv_cyc6 - t0, 55);
    n6 = dv_n6;
    set_rx(6, 1'b0);
    tick(8);
    set_rx(6, 1'b1);
    tick(20);
    check("s6_busy_in_data", busy6, 1'b1);
    rstn6 = 1'b0;
    tick(1);
    check("s6_rst_data", dout6, 8'h00);
    check("s6_rst_valid", dv6, 1'b0);
    check("s6_rst_perr", perr6, 1'b0);
    check("s6_rst_ferr", ferr6, 1'b0);
    check("s6_rst_busy", busy6, 1'b0);
    rstn6 = 1'b1;
    tick(80);
    check("s6_no_valid", dv_n6 - n6, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
